pulse_width_meter: RTL

- Receive-side counterpart of the one-shot window generator.
- Measures the length, in enabled clock cycles, of each active-high window on i_active and reports it as a one-cycle result strobe.
- Flags windows that exceed the parameter ceiling and compares each result against an expected width.
- Sits downstream of counter-driven strobes (e.g. a generator's active output) for self-check and timing telemetry.

---
 rtl/pulse_width_meter.sv | 112 +++++++++++
 1 files changed

// File: rtl/pulse_width_meter.sv
// Measures each active-high window on i_active in enabled cycles and publishes a one-cycle result strobe.
// Optional PWM_INPUT_SYNC_EN adds a 2-flop input synchronizer (results delayed by 2 cycles).
module pulse_width_meter #(
   parameter int MAX_WIDTH = 1023,
   parameter int CNT_W     = 10,
   parameter int EXP_WIDTH = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic             i_active,
   output logic [CNT_W-1:0] o_width,
   output logic             o_valid,
   output logic             o_overflow,
   output logic             o_match,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      WAIT_LOW = 2'd0,
      IDLE     = 2'd1,
      MEASURE  = 2'd2,
      SAT      = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sample;
   logic             publish;
   logic             publish_ovf;
   logic             publish_match;

`ifdef PWM_INPUT_SYNC_EN
   logic [1:0] sync_q;

   // Synchronizer runs on every edge so i_ce never stretches metastability settling.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], i_active};
   end

   assign sample = sync_q[1];
`else
   assign sample = i_active;
`endif

   // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      publish     = 1'b0;
      publish_ovf = 1'b0;
      if (i_ce) begin
         unique case (state_q)
            WAIT_LOW: if (!sample) state_d = IDLE;
            IDLE: begin
               if (sample) begin
                  state_d = MEASURE;
                  count_d = CNT_W'(1);
               end
            end
            MEASURE: begin
               if (!sample) begin
                  state_d = IDLE;
                  publish = 1'b1;
               end else if (count_q < MAX_C) begin
                  count_d = count_q + 1'b1;
               end else begin
                  state_d = SAT;
               end
            end
            SAT: begin
               if (!sample) begin
                  state_d     = IDLE;
                  publish     = 1'b1;
                  publish_ovf = 1'b1;
               end
            end
            default: state_d = WAIT_LOW;
         endcase
      end
   end

   assign publish_match = (EXP_WIDTH != 0) && !publish_ovf && (count_q == EXP_C);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= WAIT_LOW;
         count_q    <= '0;
         o_width    <= '0;
         o_valid    <= 1'b0;
         o_overflow <= 1'b0;
         o_match    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         o_valid <= publish;
         if (publish) begin
            o_width    <= count_q;
            o_overflow <= publish_ovf;
            o_match    <= publish_match;
         end
      end
   end

   assign o_busy = (state_q == MEASURE) || (state_q == SAT);

endmodule
